// File: rtl/ad_su_pkg.sv
// ----------------------------------------------------------------------------
// ad_su_pkg
// Shared types and constants for the ad_su issue stage and its request FIFO.
//   AS_W      operand / result width of the ad_su core (5 bits)
//   OP_ADD    op encoding for add (core cin = 0)
//   OP_SUB    op encoding for subtract (core cin = 1)
//   as_req_t  queued operation request {op, a, b}
//   as_rsp_t  captured core response {op, res, v}
// ----------------------------------------------------------------------------
package ad_su_pkg;

  localparam int AS_W = 5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic            op;
    logic [AS_W-1:0] a;
    logic [AS_W-1:0] b;
  } as_req_t;

  typedef struct packed {
    logic            op;
    logic [AS_W-1:0] res;
    logic            v;
  } as_rsp_t;

  // The core's mode input is simply "this is a subtract".
  function automatic logic op_to_cin(input logic op);
    return (op == OP_SUB);
  endfunction

endpackage

// File: rtl/as_req_fifo.sv
// ----------------------------------------------------------------------------
// as_req_fifo
// Synchronous request FIFO of as_req_t with DEPTH entries. Read and write
// pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write push_data this cycle (ignored when full)
//   push_data  request to enqueue
//   pop        discard the head this cycle (ignored when empty)
//   head       oldest entry, combinational from storage
//   full       DEPTH entries held
//   empty      no entries held
// ----------------------------------------------------------------------------
module as_req_fifo
  import ad_su_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  as_req_t push_data,
  input  logic    pop,
  output as_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  as_req_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is data only; stale contents are never observed because the
  // pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ad_su_issue_stage.sv
// ----------------------------------------------------------------------------
// ad_su_issue_stage
// Feeds the combinational 5-bit adder/subtractor core ad_su from a small
// request FIFO and captures its result into a single valid/ready output slot.
// Also keeps a saturating count of results that signalled signed overflow.
// The core itself sits beside this block in the parent.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake; in_op/in_a/in_b request fields
//   au_a/au_b/au_cin     FIFO head driven to the core (zero when empty)
//   au_s/au_v            core sum/difference and signed overflow
//   out_valid/out_ready  result handshake; out_op/out_res/out_v result fields
//   ovf_count            saturating count of captured results with v=1
// ----------------------------------------------------------------------------
module ad_su_issue_stage
  import ad_su_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [AS_W-1:0]  in_a,
  input  logic [AS_W-1:0]  in_b,
  output logic [AS_W-1:0]  au_a,
  output logic [AS_W-1:0]  au_b,
  output logic             au_cin,
  input  logic [AS_W-1:0]  au_s,
  input  logic             au_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_op,
  output logic [AS_W-1:0]  out_res,
  output logic             out_v,
  output logic [CNT_W-1:0] ovf_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  as_req_t          push_req;
  as_req_t          head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             issue;

  as_rsp_t          rsp_p0;
  logic             vld_p0;
  logic [CNT_W-1:0] ovf_p0;

  assign push_req = '{op: in_op, a: in_a, b: in_b};

  // Refuses a push whenever full, even if the head pops in the same cycle;
  // this keeps in_ready independent of out_ready.
  assign in_ready = !rst && !fifo_full;
  assign push     = in_valid && in_ready;

  // Head may move into the slot when the slot is empty or is being drained.
  assign issue = !fifo_empty && (!vld_p0 || out_ready);

  as_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (issue),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Core operands: zero while nothing is queued so the core sees a quiet bus.
  assign au_a   = fifo_empty ? '0   : head.a;
  assign au_b   = fifo_empty ? '0   : head.b;
  assign au_cin = fifo_empty ? 1'b0 : op_to_cin(head.op);

  // Stage p0: result slot capturing the core output for the issued head
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      rsp_p0 <= '0;
      ovf_p0 <= '0;
    end else if (issue) begin
      vld_p0     <= 1'b1;
      rsp_p0.op  <= head.op;
      rsp_p0.res <= au_s;
      rsp_p0.v   <= au_v;
      if (au_v) begin
        ovf_p0 <= sat_inc(ovf_p0);
      end
    end else if (out_ready) begin
      // Slot consumed with nothing behind it; data fields keep their value.
      vld_p0 <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_op    = rsp_p0.op;
  assign out_res   = rsp_p0.res;
  assign out_v     = rsp_p0.v;
  assign ovf_count = ovf_p0;

endmodule

// File: tb/tb_ad_su_issue_stage.sv
// ----------------------------------------------------------------------------
// tb_ad_su_issue_stage
// Bench for ad_su_issue_stage with a stand-in ad_su core built from explicit
// carry bits. Requests go through a driver that records the model's expected
// response on acceptance; an independent monitor pops and compares whenever a
// result is consumed.
// ----------------------------------------------------------------------------
module tb_ad_su_issue_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_op;
  logic [4:0] in_a;
  logic [4:0] in_b;
  logic [4:0] au_a;
  logic [4:0] au_b;
  logic       au_cin;
  logic [4:0] au_s;
  logic       au_v;
  logic       out_valid;
  logic       out_ready;
  logic       out_op;
  logic [4:0] out_res;
  logic       out_v;
  logic [7:0] ovf_count;

  int vectors = 0;
  int miscompares = 0;
  int model_ovf = 0;
  int cyc = 0;
  int exp_q[$];

  ad_su_issue_stage #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .au_a      (au_a),
    .au_b      (au_b),
    .au_cin    (au_cin),
    .au_s      (au_s),
    .au_v      (au_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_res   (out_res),
    .out_v     (out_v),
    .ovf_count (ovf_count)
  );

  // Stand-in ad_su core: ripple add of a and (b or ~b) with cin; overflow is
  // carry into the MSB xor carry out of the MSB.
  logic [4:0] core_bx;
  logic [5:0] core_sum;
  logic [4:0] core_low;
  always_comb begin
    core_bx  = au_cin ? ~au_b : au_b;
    core_sum = {1'b0, au_a} + {1'b0, core_bx} + {5'b0, au_cin};
    core_low = {1'b0, au_a[3:0]} + {1'b0, core_bx[3:0]} + {4'b0, au_cin};
    au_s     = core_sum[4:0];
    au_v     = core_sum[5] ^ core_low[4];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: signed integer arithmetic on the decoded operands.
  function automatic int model(input int op, input int a, input int b, output int v);
    int sa, sb, r, res;
    sa  = (a >= 16) ? a - 32 : a;
    sb  = (b >= 16) ? b - 32 : b;
    r   = (op != 0) ? sa - sb : sa + sb;
    v   = (r > 15 || r < -16) ? 1 : 0;
    res = ((op != 0) ? (a + (31 - b) + 1) : (a + b)) % 32;
    return (op << 6) | (res << 1) | v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed at the next posedge when valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {25'd0, out_op, out_res, out_v}, -1);
      end else begin
        chk("result", {25'd0, out_op, out_res, out_v}, exp_q.pop_front());
      end
    end
  end

  // Inputs change at posedge+2; acceptance is decided from in_ready at negedge.
  task automatic try_send(input int op, input int a, input int b, input int limit,
                          output bit ok);
    int v, e;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_op    = op[0];
    in_a     = a[4:0];
    in_b     = b[4:0];
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(op, a, b, v);
        exp_q.push_back(e);
        model_ovf += v;
        ok = 1'b1;
      end
      @(posedge clk);
      #2;
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input int op, input int a, input int b);
    bit ok;
    try_send(op, a, b, 200, ok);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 300) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Single add 3+4 from an idle, empty stage, checking latency and fields.
  task automatic single_add();
    int v, e;
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_a     = 5'd3;
    in_b     = 5'd4;
    @(negedge clk);
    chk("sa_in_ready", in_ready, 1);
    e = model(0, 3, 4, v);
    exp_q.push_back(e);
    model_ovf += v;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("sa_head", {au_cin, au_a, au_b}, {1'b0, 5'd3, 5'd4});
    chk("sa_valid_early", out_valid, 0);
    @(negedge clk);
    chk("sa_valid", out_valid, 1);
    chk("sa_res", {out_res, out_v}, {5'd7, 1'b0});
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit ok;
    bit done;
    int t0, stable_res, nvalid;

    rst = 1'b1;
    in_valid = 1'b0;
    in_op = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_data", {out_op, out_res, out_v}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2;

    single_add();
    wait_drain();

    // Subtract 5-7, then overflowing add 15+1
    send(1, 5, 7);
    send(0, 15, 1);
    wait_drain();
    chk("ovf_count_one", ovf_count, 1);

    // Backpressure: 4 in FIFO + 1 in slot, the sixth must be refused
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      try_send(0, i + 1, 2 * i, 3, ok);
      chk("bp_accept", ok, 1);
    end
    try_send(1, 9, 9, 6, ok);
    chk("bp_sixth_refused", ok, 0);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    stable_res = {out_op, out_res, out_v};
    repeat (3) begin
      @(negedge clk);
      chk("bp_stable", {out_op, out_res, out_v}, stable_res);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    nvalid = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("bp_drain_rate", nvalid, 5);
    wait_drain();

    // Exhaustive stream: all adds then all subtracts
    t0 = cyc;
    for (int op = 0; op < 2; op++)
      for (int a = 0; a < 32; a++)
        for (int b = 0; b < 32; b++)
          send(op, a, b);
    wait_drain();
    chk("stream_cycles_ok", (cyc - t0) <= 2048 + 6, 1);
    chk("ovf_count_sat", ovf_count, (model_ovf > 255) ? 255 : model_ovf);

    // Random requests with random consumer stalls
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++)
          send($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with 3 queued and 1 held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 10 + i, 3);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    model_ovf = 0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_valid", out_valid, 0);
    end
    chk("mid_rst_ovf", ovf_count, 0);
    @(posedge clk);
    #2;
    single_add();
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
